// File: rtl/round_judge.sv
// round_judge: round controller for the 1P factorization game (capture target, countdown, judge answer).
// Optional feature: define ROUND_JUDGE_RETRY_EN to allow one retry after a wrong answer per round.
module round_judge #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIME_LIMIT = 9,
  parameter int HOLD_SEC   = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RUN_IN,
  input  logic [3:0] NUM,
  input  logic [3:0] ANS,
  input  logic       SUBMIT,
  output logic [3:0] STATE,
  output logic [6:0] TARGET,
  output logic [3:0] TIME_LEFT,
  output logic [3:0] SCORE,
  output logic       WIN,
  output logic       LOSE
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'h0,
    S_CAP_T = 4'h1,
    S_CAP_U = 4'h2,
    S_ASK   = 4'h3,
    S_CHECK = 4'h4,
    S_WIN   = 4'h8,
    S_LOSE  = 4'h9
  } state_t;

  state_t      state;
  logic [25:0] tick_cnt;
  logic        tick;
  logic        run_q;
  logic        run_edge;
  logic [3:0]  tens;
  logic [6:0]  target;
  logic [3:0]  time_left;
  logic [3:0]  score;
  logic [3:0]  ans_q;
  logic [3:0]  div;
  logic [6:0]  rem;
  logic [3:0]  hold_cnt;
  logic        check_done;
  logic        check_ok;
`ifdef ROUND_JUDGE_RETRY_EN
  logic        retry_used;
`endif

  assign tick = (tick_cnt == 26'(CLK_HZ - 1));

  // Claims only try prime divisors: any composite d < TARGET dividing TARGET implies a
  // smaller prime does too, and skipping 4, 6, 8, 9 keeps TARGET=97 under 120 cycles.
  function automatic logic [3:0] next_div(input logic [3:0] d);
    case (d)
      4'd2:    next_div = 4'd3;
      4'd3:    next_div = 4'd5;
      4'd5:    next_div = 4'd7;
      default: next_div = 4'd10;
    endcase
  endfunction

  always_comb begin
    check_done = 1'b0;
    check_ok   = 1'b0;
    if (ans_q != 4'd0) begin
      if (ans_q < 4'd2 || ans_q > 4'd9 || {3'b0, ans_q} >= target) begin
        check_done = 1'b1;
      end else if (rem == 7'd0) begin
        check_done = 1'b1;
        check_ok   = 1'b1;
      end else if (rem < {3'b0, div}) begin
        check_done = 1'b1;
      end
    end else begin
      if (div > 4'd9 || {3'b0, div} >= target) begin
        check_done = 1'b1;
        check_ok   = 1'b1;
      end else if (rem == 7'd0) begin
        check_done = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      run_q      <= 1'b0;
      run_edge   <= 1'b0;
      tens       <= '0;
      target     <= '0;
      time_left  <= '0;
      score      <= '0;
      ans_q      <= '0;
      div        <= '0;
      rem        <= '0;
      hold_cnt   <= '0;
`ifdef ROUND_JUDGE_RETRY_EN
      retry_used <= 1'b0;
`endif
    end else begin
      run_q    <= RUN_IN;
      run_edge <= RUN_IN & ~run_q;
      tick_cnt <= tick ? '0 : tick_cnt + 26'd1;
      // Every transition below also clears the tick counter.
      case (state)
        S_IDLE: begin
          if (run_edge) begin
            state    <= S_CAP_T;
            tick_cnt <= '0;
          end
        end
        S_CAP_T: begin
          if (tick_cnt == 26'd0) tens <= NUM;
`ifdef ROUND_JUDGE_RETRY_EN
          retry_used <= 1'b0;
`endif
          if (tick) begin
            state    <= S_CAP_U;
            tick_cnt <= '0;
          end
        end
        S_CAP_U: begin
          target    <= {3'b0, tens} * 7'd10 + {3'b0, NUM};
          time_left <= 4'(TIME_LIMIT);
          state     <= S_ASK;
          tick_cnt  <= '0;
        end
        S_ASK: begin
          if (SUBMIT) begin
            ans_q    <= ANS;
            div      <= (ANS == 4'd0) ? 4'd2 : ANS;
            rem      <= target;
            state    <= S_CHECK;
            tick_cnt <= '0;
          end else if (tick) begin
            if (time_left == 4'd1) begin
              time_left <= 4'd0;
              state     <= S_LOSE;
              hold_cnt  <= '0;
              tick_cnt  <= '0;
            end else begin
              time_left <= time_left - 4'd1;
            end
          end
        end
        S_CHECK: begin
          if (check_done) begin
            tick_cnt <= '0;
            hold_cnt <= '0;
            if (check_ok) begin
              state <= S_WIN;
              if (score < 4'd9) score <= score + 4'd1;
            end else begin
`ifdef ROUND_JUDGE_RETRY_EN
              if (!retry_used) begin
                retry_used <= 1'b1;
                state      <= S_ASK;
              end else begin
                state <= S_LOSE;
              end
`else
              state <= S_LOSE;
`endif
            end
          end else if (rem < {3'b0, div}) begin
            div <= next_div(div);
            rem <= target;
          end else begin
            rem <= rem - {3'b0, div};
          end
        end
        S_WIN, S_LOSE: begin
          if (tick) begin
            if (hold_cnt == 4'(HOLD_SEC - 1)) begin
              state    <= S_IDLE;
              tick_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign STATE     = state;
  assign TARGET    = target;
  assign TIME_LEFT = time_left;
  assign SCORE     = score;
  assign WIN       = (state == S_WIN);
  assign LOSE      = (state == S_LOSE);

endmodule

// File: tb/tb_round_judge.sv
// Testbench for round_judge: scoreboard of expected round outcomes checked against two DUTs
// (TIME_LIMIT 9 for the main rounds, TIME_LIMIT 3 for the timeout boundary).
module tb_round_judge;
  localparam int CLK_HZ = 10;
  localparam int TL_A   = 9;
  localparam int TL_B   = 3;
  localparam int HOLD   = 3;
  localparam logic [3:0] ST_IDLE = 4'h0, ST_CAPT = 4'h1, ST_ASK = 4'h3,
                         ST_CHECK = 4'h4, ST_WIN = 4'h8, ST_LOSE = 4'h9;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       RUN_IN = 1'b0;
  logic       SUBMIT = 1'b0;
  logic [3:0] NUM = 4'd0;
  logic [3:0] ANS = 4'd0;
  logic [3:0] state_a, time_a, score_a, state_b, time_b, score_b;
  logic [6:0] target_a, target_b;
  logic       win_a, lose_a, win_b, lose_b;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_score = 0;
`ifdef ROUND_JUDGE_RETRY_EN
  bit retry_avail = 1'b0;
`endif

  typedef struct {
    logic [3:0] st;
    logic [3:0] sc;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  round_judge #(.CLK_HZ(CLK_HZ), .TIME_LIMIT(TL_A), .HOLD_SEC(HOLD)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .RUN_IN(RUN_IN), .NUM(NUM), .ANS(ANS), .SUBMIT(SUBMIT),
    .STATE(state_a), .TARGET(target_a), .TIME_LEFT(time_a), .SCORE(score_a),
    .WIN(win_a), .LOSE(lose_a)
  );

  round_judge #(.CLK_HZ(CLK_HZ), .TIME_LIMIT(TL_B), .HOLD_SEC(HOLD)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .RUN_IN(RUN_IN), .NUM(NUM), .ANS(ANS), .SUBMIT(SUBMIT),
    .STATE(state_b), .TARGET(target_b), .TIME_LEFT(time_b), .SCORE(score_b),
    .WIN(win_b), .LOSE(lose_b)
  );

  function automatic bit model_correct(input int tgt, input int a);
    if (a != 0) return (a >= 2 && a <= 9 && a < tgt && (tgt % a) == 0);
    for (int d = 2; d <= 9; d++) begin
      if (d < tgt && (tgt % d) == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [3:0] st_of(input bit b);
    return b ? state_b : state_a;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic predict(input int tgt, input int a);
    exp_t e;
    if (model_correct(tgt, a)) begin
      if (exp_score < 9) exp_score++;
      e.st = ST_WIN;
    end else begin
`ifdef ROUND_JUDGE_RETRY_EN
      if (retry_avail) begin
        retry_avail = 1'b0;
        e.st = ST_ASK;
      end else begin
        e.st = ST_LOSE;
      end
`else
      e.st = ST_LOSE;
`endif
    end
    e.sc = 4'(exp_score);
    sb.push_back(e);
  endtask

  task automatic wait_state(input bit b, input logic [3:0] s, input int limit, output int n);
    n = 0;
    while (st_of(b) !== s && n < limit) begin
      cyc();
      n++;
    end
    if (st_of(b) !== s) n = -1;
  endtask

  task automatic wait_idle(input bit b);
    int n;
    wait_state(b, ST_IDLE, 300, n);
  endtask

  // n returns the cycle count from observing CAP_T to observing ASK (-1 on timeout).
  task automatic start_round(input int t, input int u, output int n);
    NUM = 4'(t);
    RUN_IN = 1'b1;
    cyc();
    RUN_IN = 1'b0;
    wait_state(1'b0, ST_CAPT, 5, n);
    repeat (3) cyc();
    NUM = 4'(u);
    wait_state(1'b0, ST_ASK, CLK_HZ + 5, n);
    if (n >= 0) n += 3;
`ifdef ROUND_JUDGE_RETRY_EN
    retry_avail = 1'b1;
`endif
  endtask

  task automatic submit_wait(input int a, input bit b, output logic [3:0] st, output int n);
    ANS = 4'(a);
    SUBMIT = 1'b1;
    cyc();
    SUBMIT = 1'b0;
    n = 0;
    while (st_of(b) === ST_CHECK && n < 200) begin
      cyc();
      n++;
    end
    st = st_of(b);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    cyc();
    RST_N = 1'b1;
    cyc();
    exp_score = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    n_cmp++;
    if ({state_a, target_a, time_a, score_a, win_a, lose_a} !== 21'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got state %h target %0d time %0d score %0d win %b lose %b, expected all 0",
               state_a, target_a, time_a, score_a, win_a, lose_a);
    end
    RST_N = 1'b1;
    cyc();
  endtask

  task automatic test_valid_round();
    int n;
    logic [3:0] st;
    exp_t e;
    start_round(4, 2, n);
    n_cmp++;
    if (n != CLK_HZ + 1) begin
      n_fail++;
      $display("[TB] FAIL capt_to_ask: got %0d cycles, expected %0d", n, CLK_HZ + 1);
    end
    n_cmp++;
    if (target_a !== 7'd42 || time_a !== 4'(TL_A)) begin
      n_fail++;
      $display("[TB] FAIL load: got target %0d time %0d, expected 42 and %0d", target_a, time_a, TL_A);
    end
    predict(42, 7);
    submit_wait(7, 1'b0, st, n);
    e = sb.pop_front();
    n_cmp++;
    if (st !== e.st || score_a !== e.sc || n > 120 || win_a !== 1'b1 || lose_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL valid_round: got state %h score %0d win %b lose %b in %0d cycles, expected %h %0d 1 0 within 120",
               st, score_a, win_a, lose_a, n, e.st, e.sc);
    end
    wait_state(1'b0, ST_IDLE, 60, n);
    n_cmp++;
    if (n != HOLD * CLK_HZ || target_a !== 7'd42 || time_a !== 4'(TL_A) || score_a !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL hold: got %0d cycles target %0d time %0d score %0d, expected %0d 42 %0d 1",
               n, target_a, time_a, score_a, HOLD * CLK_HZ, TL_A);
    end
  endtask

  task automatic test_wrong_factor();
    int n;
    logic [3:0] st;
    logic [3:0] tl_before;
    exp_t e;
    start_round(4, 2, n);
    repeat (12) cyc();
    tl_before = time_a;
    predict(42, 5);
    submit_wait(5, 1'b0, st, n);
    e = sb.pop_front();
    n_cmp++;
    if (st !== e.st || score_a !== e.sc) begin
      n_fail++;
      $display("[TB] FAIL wrong_factor: got state %h score %0d, expected %h %0d", st, score_a, e.st, e.sc);
    end
`ifdef ROUND_JUDGE_RETRY_EN
    n_cmp++;
    if (time_a !== tl_before || tl_before !== 4'(TL_A - 1)) begin
      n_fail++;
      $display("[TB] FAIL retry_time: got %0d (before %0d), expected %0d", time_a, tl_before, TL_A - 1);
    end
    predict(42, 6);
    submit_wait(6, 1'b0, st, n);
    e = sb.pop_front();
    n_cmp++;
    if (st !== e.st || score_a !== e.sc) begin
      n_fail++;
      $display("[TB] FAIL retry_win: got state %h score %0d, expected %h %0d", st, score_a, e.st, e.sc);
    end
    wait_idle(1'b0);
    start_round(4, 2, n);
    for (int k = 0; k < 2; k++) begin
      predict(42, (k == 0) ? 5 : 4);
      submit_wait((k == 0) ? 5 : 4, 1'b0, st, n);
      e = sb.pop_front();
      n_cmp++;
      if (st !== e.st || score_a !== e.sc) begin
        n_fail++;
        $display("[TB] FAIL retry_second_%0d: got state %h score %0d, expected %h %0d", k, st, score_a, e.st, e.sc);
      end
    end
`endif
    wait_idle(1'b0);
  endtask

  task automatic test_judge();
    int tab_t[4] = '{9, 9, 0, 0};
    int tab_u[4] = '{7, 1, 2, 2};
    int tab_a[4] = '{0, 0, 0, 2};
    int t, u, a, n;
    logic [3:0] st;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        t = tab_t[i];
        u = tab_u[i];
        a = tab_a[i];
      end else begin
        t = $urandom_range(0, 9);
        u = $urandom_range(0, 9);
        a = $urandom_range(0, 15);
      end
      start_round(t, u, n);
      do begin
        predict(t * 10 + u, a);
        submit_wait(a, 1'b0, st, n);
        e = sb.pop_front();
        n_cmp++;
        if (st !== e.st || score_a !== e.sc || n > 120) begin
          n_fail++;
          $display("[TB] FAIL judge T=%0d ANS=%0d: got state %h score %0d after %0d cycles, expected %h %0d within 120",
                   t * 10 + u, a, st, score_a, n, e.st, e.sc);
        end
      end while (e.st == ST_ASK);
      wait_idle(1'b0);
    end
  endtask

  task automatic test_run_toggle();
    int n;
    logic [3:0] st;
    exp_t e;
    start_round(1, 5, n);
    for (int k = 0; k < 6; k++) begin
      RUN_IN = ~RUN_IN;
      cyc();
    end
    RUN_IN = 1'b0;
    cyc();
    n_cmp++;
    if (state_a !== ST_ASK || target_a !== 7'd15) begin
      n_fail++;
      $display("[TB] FAIL run_toggle: got state %h target %0d, expected %h 15", state_a, target_a, ST_ASK);
    end
    predict(15, 5);
    submit_wait(5, 1'b0, st, n);
    e = sb.pop_front();
    n_cmp++;
    if (st !== e.st || score_a !== e.sc) begin
      n_fail++;
      $display("[TB] FAIL run_toggle_judge: got state %h score %0d, expected %h %0d", st, score_a, e.st, e.sc);
    end
    wait_idle(1'b0);
  endtask

  task automatic test_reset_mid_check();
    int n;
    start_round(9, 7, n);
    ANS = 4'd0;
    SUBMIT = 1'b1;
    cyc();
    SUBMIT = 1'b0;
    repeat (20) cyc();
    n_cmp++;
    if (state_a !== ST_CHECK || score_a !== 4'(exp_score)) begin
      n_fail++;
      $display("[TB] FAIL pre_reset: got state %h score %0d, expected %h %0d", state_a, score_a, ST_CHECK, exp_score);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({state_a, target_a, time_a, score_a, win_a, lose_a} !== 21'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got state %h target %0d time %0d score %0d win %b lose %b, expected all 0",
               state_a, target_a, time_a, score_a, win_a, lose_a);
    end
    cyc();
    RST_N = 1'b1;
    cyc();
    exp_score = 0;
    sb.delete();
  endtask

  task automatic test_timeout();
    int n;
    logic [3:0] st;
    exp_t e;
    do_reset();
    start_round(4, 2, n);
    wait_state(1'b1, ST_LOSE, 4 * CLK_HZ, n);
    n_cmp++;
    if (n != TL_B * CLK_HZ || time_b !== 4'd0 || lose_b !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL timeout: got %0d cycles time %0d lose %b, expected %0d 0 1", n, time_b, lose_b, TL_B * CLK_HZ);
    end
    wait_idle(1'b1);
    wait_idle(1'b0);
    start_round(4, 2, n);
    repeat (TL_B * CLK_HZ - 1) cyc();
    predict(42, 7);
    submit_wait(7, 1'b1, st, n);
    n_cmp++;
    if (st !== ST_WIN || time_b !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL submit_on_last_tick: got state %h time %0d, expected %h 1", st, time_b, ST_WIN);
    end
    wait_state(1'b0, ST_WIN, 130, n);
    e = sb.pop_front();
    n_cmp++;
    if (state_a !== e.st || score_a !== e.sc) begin
      n_fail++;
      $display("[TB] FAIL last_tick_main: got state %h score %0d, expected %h %0d", state_a, score_a, e.st, e.sc);
    end
    wait_idle(1'b1);
    wait_idle(1'b0);
  endtask

  task automatic test_saturation();
    int n;
    logic [3:0] st;
    exp_t e;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      start_round(4, 2, n);
      predict(42, 7);
      submit_wait(7, 1'b0, st, n);
      e = sb.pop_front();
      n_cmp++;
      if (st !== e.st || score_a !== e.sc) begin
        n_fail++;
        $display("[TB] FAIL saturation_round_%0d: got state %h score %0d, expected %h %0d", r, st, score_a, e.st, e.sc);
      end
      wait_idle(1'b0);
    end
    n_cmp++;
    if (score_a !== 4'd9) begin
      n_fail++;
      $display("[TB] FAIL saturation_final: got score %0d, expected 9", score_a);
    end
  endtask

  initial begin
    test_reset();
    test_valid_round();
    test_wrong_factor();
    test_judge();
    test_run_toggle();
    test_reset_mid_check();
    test_timeout();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/round_judge.md
# round_judge

Game-round controller for the 1P factorization game, directly downstream of the digit generator. It captures two successive `NUM` digits as a two-digit target, runs a per-round countdown, accepts the player's factor answer and judges it with a sequential remainder unit. It publishes `STATE` back to the generator, which releases its run latch when `STATE` reaches a final value (WIN/LOSE).

## Interface

**Parameters**
- `CLK_HZ`, default 50_000_000: clock cycles per internal 1 Hz tick. Benches use 10.
- `TIME_LIMIT`, default 9: answer window in seconds, 1..15.
- `HOLD_SEC`, default 3: seconds that WIN/LOSE is held before returning to IDLE.

**Ports**
- `CLK` input, 1: system clock.
- `RST_N` input, 1: asynchronous, active-low reset.
- `RUN_IN` input, 1: generator running; its rising edge starts a round.
- `NUM` input, 4: digit from the generator, 0..9.
- `ANS` input, 4: player answer. 0 = "no factor 2..9" claim; otherwise the factor.
- `SUBMIT` input, 1: one-cycle pulse that commits `ANS`.
- `STATE` output, 4: current FSM state code.
- `TARGET` output, 7: captured target, 0..99.
- `TIME_LEFT` output, 4: remaining seconds.
- `SCORE` output, 4: wins, saturating at 9.
- `WIN` output, 1: high while in WIN.
- `LOSE` output, 1: high while in LOSE.

## Operation
- State codes: IDLE 4'h0, CAP_T 4'h1, CAP_U 4'h2, ASK 4'h3, CHECK 4'h4, WIN 4'h8, LOSE 4'h9.
- Internal tick:
  - 26-bit counter; `tick` pulses when it equals `CLK_HZ-1`.
  - The counter clears on every state change.
- IDLE:
  - Registered edge detect on `RUN_IN`; a rising edge moves to CAP_T.
  - `RUN_IN` is ignored in every other state.
- CAP_T: `tens <= NUM` on the entry cycle; on `tick` go to CAP_U.
- CAP_U:
  - `TARGET <= tens*10 + NUM`, computed in 7 bits (max 99).
  - Load `TIME_LEFT <= TIME_LIMIT` and go to ASK.
- ASK:
  - `SUBMIT` latches `ANS` and moves to CHECK.
  - Otherwise `tick` decrements `TIME_LEFT`. A `tick` while `TIME_LEFT==1` sets `TIME_LEFT` to 0 and moves to LOSE.
- CHECK uses repeated subtraction, one subtraction per cycle.
  - Factor answer:
    - Correct iff 2 ≤ `ANS` ≤ 9, `ANS` < `TARGET`, and `TARGET` mod `ANS` == 0.
    - `ANS` of 1 or 10..15 is wrong with no iterations run.
  - Claim (`ANS`=0):
    - Iterate d=2..9, considering only d < `TARGET`.
    - Correct iff no such d divides `TARGET`.
    - `TARGET` 0, 1, 2 have no candidate d, so the claim is correct.
  - Correct answer: go to WIN and set `SCORE <= min(SCORE+1, 9)`. Wrong answer: go to LOSE.
- WIN/LOSE:
  - `WIN`/`LOSE` are asserted for the whole state.
  - After `HOLD_SEC` ticks, return to IDLE. `TARGET`, `TIME_LEFT` and `SCORE` hold their values.
- `SUBMIT` outside ASK is ignored.

## Timing
- Reset values: every output and internal register is 0; `STATE` = IDLE. The reset takes effect immediately and asynchronously, from any state including mid-CHECK.
- `RUN_IN` edge to `STATE`=CAP_T: 2 cycles (1 cycle of edge detect, then the transition).
- CAP_T entry to CAP_U entry: exactly `CLK_HZ` cycles. CAP_U to ASK: 1 cycle.
- `SUBMIT` to CHECK: 1 cycle.
- CHECK latency: ≤ 120 cycles. Worst case is a claim on `TARGET`=97, about 100 subtractions.
- Simultaneous `SUBMIT` and the final `tick` in ASK: `SUBMIT` wins, `TIME_LEFT` holds, and the answer is judged.
- `TIME_LEFT` changes only on `tick` in ASK and on the load in CAP_U.
- `SCORE` updates on the CHECK→WIN transition cycle.

## Configuration
- `ROUND_JUDGE_RETRY_EN` defined:
  - The first wrong factor or claim in a round returns CHECK → ASK with `TIME_LEFT` unchanged and the tick counter cleared.
  - A second wrong answer goes to LOSE.
  - The retry flag clears in CAP_T.
  - A timeout always goes to LOSE.
- Not defined: any wrong answer goes CHECK → LOSE. No retry logic is synthesized.

## Test plan
- Round with a valid factor (`CLK_HZ`=10):
  - Stimulus: `RUN_IN` rises with `NUM`=4, `NUM`=2 at the CAP_T tick, then `SUBMIT` with `ANS`=7.
  - Response: `TARGET`=42, `TIME_LEFT`=9, `STATE`=4'h8 within 120 cycles of CHECK entry, `SCORE`=1.
- Wrong factor:
  - Stimulus: `TARGET`=42, `ANS`=5.
  - Response without macro: LOSE.
  - Response with `ROUND_JUDGE_RETRY_EN`: back to ASK with `TIME_LEFT` unchanged; `ANS`=6 then gives WIN; a second wrong `ANS` gives LOSE.
- Claim checks:
  - `TARGET`=97 with `ANS`=0 → WIN.
  - `TARGET`=91 with `ANS`=0 → LOSE (7 divides 91).
  - `TARGET`=2 with `ANS`=0 → WIN; `TARGET`=2 with `ANS`=2 → LOSE.
- Timeout and boundary:
  - `TIME_LIMIT`=3, no `SUBMIT` → LOSE after 3 ticks with `TIME_LEFT`=0.
  - Repeat with `SUBMIT` (`ANS`=7, `TARGET`=42) on the final tick → WIN with `TIME_LEFT`=1.
- Reset and saturation:
  - Deassert `RST_N` mid-CHECK → all outputs 0 and IDLE, without waiting for a clock edge.
  - Ten consecutive WINs → `SCORE` holds at 9.
  - `RUN_IN` toggling during ASK has no effect.
